// File: rtl/vga_pixel_fifo_ctrl.sv
// Pixel FIFO controller between the NES pixel generator and the VGA output path.
// Owns a 16 x 30-bit distributed RAM, pointers, occupancy, prefill gating and underflow flag.
module vga_pixel_fifo_ctrl #(
   parameter int unsigned PREFILL  = 8,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_wr_valid,
   input  logic [29:0] i_wr_data,
   output logic        o_wr_ready,
   input  logic        i_rd_ready,
   output logic        o_rd_valid,
   output logic [29:0] o_rd_data,
   output logic [4:0]  o_count,
   output logic        o_almost_full,
   output logic        o_underflow,
   output logic        o_streaming
);

   localparam logic [4:0] PrefillCnt = 5'(PREFILL);
   localparam logic [4:0] AfCnt      = 5'(AF_LEVEL);
   localparam logic [4:0] FullCnt    = 5'd16;

   typedef enum logic [0:0] {StFill, StStream} state_e;

   state_e      r_state, w_state_next;
   logic [3:0]  r_wr_ptr, r_rd_ptr;
   logic [4:0]  r_count, w_count_next;
   logic        r_underflow, w_underflow_next;
   logic [29:0] r_mem [16];

   logic w_full, w_empty, w_push, w_pop;

   assign w_full     = (r_count == FullCnt);
   assign w_empty    = (r_count == 5'd0);
   assign o_wr_ready = !w_full && !i_flush;
   assign o_rd_valid = (r_state == StStream) && !w_empty && !i_flush;
   assign w_push     = i_wr_valid && o_wr_ready;
   assign w_pop      = i_rd_ready && o_rd_valid;

   // Dual-port RAM: synchronous write on port A, show-ahead async read on port B.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];

   always_comb begin
      w_count_next = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 5'd1;
         2'b01:   w_count_next = r_count - 5'd1;
         default: w_count_next = r_count;
      endcase
   end

   always_comb begin
      w_state_next     = r_state;
      w_underflow_next = r_underflow;
      if (i_flush) begin
         w_state_next     = StFill;
         w_underflow_next = 1'b0;
      end else begin
         if (r_state == StFill && w_count_next >= PrefillCnt) begin
            w_state_next = StStream;
         end
         if (r_state == StStream && w_empty && i_rd_ready) begin
            w_underflow_next = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StFill;
         r_wr_ptr    <= 4'd0;
         r_rd_ptr    <= 4'd0;
         r_count     <= 5'd0;
         r_underflow <= 1'b0;
      end else if (i_flush) begin
         r_state     <= StFill;
         r_wr_ptr    <= 4'd0;
         r_rd_ptr    <= 4'd0;
         r_count     <= 5'd0;
         r_underflow <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         r_underflow <= w_underflow_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 4'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 4'd1;
         end
      end
   end

   assign o_count       = r_count;
   assign o_almost_full = (r_count >= AfCnt);
   assign o_underflow   = r_underflow;
   assign o_streaming   = (r_state == StStream);

endmodule

// File: doc/vga_pixel_fifo_ctrl.md
Name: vga_pixel_fifo_ctrl

Overview:
- Controller and sequencer for a 16-entry x 30-bit dual-port distributed RAM used as a pixel FIFO between the NES pixel generator and the VGA output path. One pixel is 3 x 10-bit RGB.
- RAM port A is the write side; port B is the read side.
- The block owns the pointers, occupancy count, prefill/stream state machine, flow-control handshakes and underflow monitoring.
- The RAM is instantiated inside this block (30-bit data, 4-bit addresses, synchronous write, asynchronous read).

Parameters:
- PREFILL, 8: occupancy that must be reached after reset or flush before reads are released; legal range 1..16.
- AF_LEVEL, 12: occupancy at or above which almost_full asserts; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of pointers, count, state and sticky flag.
- wr_valid  input  1  producer has a pixel.
- wr_data  input  30  pixel {R[29:20], G[19:10], B[9:0]}.
- wr_ready  output  1  FIFO can accept a pixel this cycle.
- rd_ready  input  1  consumer takes the pixel on rd_data this cycle.
- rd_valid  output  1  rd_data is valid.
- rd_data  output  30  head pixel, driven asynchronously from RAM port B.
- count  output  5  occupancy, 0..16.
- almost_full  output  1  count >= AF_LEVEL.
- underflow  output  1  sticky; the consumer requested data while streaming and empty.
- streaming  output  1  state machine is in STREAM.

Behaviour:
- Reset (asynchronous, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0, state=FILL, underflow=0.
  - Outputs: wr_ready=1, rd_valid=0, almost_full=0, streaming=0, rd_data=RAM[0].
  - RAM contents are not cleared.
- Pointer and address rules:
  - wr_ptr and rd_ptr are 4-bit and wrap 15->0 naturally.
  - RAM addr_a=wr_ptr, addr_b=rd_ptr, din_a=wr_data, wren_a=push.
- Combinational outputs:
  - full = (count==16); empty = (count==0).
  - wr_ready = !full && !flush.
  - rd_valid = (state==STREAM) && !empty && !flush.
- Transfer rules:
  - push = wr_valid && wr_ready: RAM[wr_ptr] is written at the edge and wr_ptr increments.
  - pop = rd_ready && rd_valid: rd_ptr increments.
  - count update: push only +1; pop only -1; push and pop together, count unchanged.
- Latency:
  - A written pixel is visible on rd_data the cycle after the push edge, provided rd_valid is high.
  - With async read, rd_data follows rd_ptr combinationally (show-ahead).
- State machine:
  - FILL -> STREAM when count (after this cycle's update) >= PREFILL; streaming goes high the cycle after.
  - STREAM -> FILL only on flush or rst. Running empty in STREAM does not return to FILL; rd_valid simply drops.
- Underflow:
  - underflow sets when state==STREAM && empty && rd_ready && !flush.
  - It stays set until flush or rst.
  - rd_ready in FILL never sets it.
- Boundary cases:
  - Full plus simultaneous wr_valid and rd_ready: the pop proceeds, the push is refused (wr_ready was 0), count goes 16->15.
  - Empty plus simultaneous wr_valid and rd_ready: the push proceeds, no pop (rd_valid was 0), count goes 0->1.
  - Flush has priority over push and pop that cycle: wr_ready=rd_valid=0, no RAM write. Next edge: pointers=0, count=0, state=FILL, underflow=0.
  - rst mid-stream: immediate return to reset values without waiting for a clock edge.
- count never exceeds 16 and never wraps below 0. Verification asserts this every cycle.

Test Plan:
- Reset then idle: rst pulse, no traffic -> wr_ready=1, rd_valid=0, count=0, streaming=0, underflow=0.
- Prefill gating (PREFILL=8): push 7 pixels 0x0000001..0x0000007 with rd_ready=1 -> rd_valid=0, count=7. Push the 8th -> next cycle streaming=1, rd_valid=1, rd_data=0x0000001; pops return 1..8 in order.
- Full and wrap: fill 16 pixels with rd_ready=0 -> count=16, wr_ready=0, almost_full=1 from count=12. Hold wr_valid with new data -> no write. Pop 1 and push 1 the same cycle -> count=15 then 16. Run more than 32 pixels through to cover pointer wrap; data order is preserved.
- Simultaneous push/pop at steady state: count=5, wr_valid=rd_ready=1 for 20 cycles -> count stays 5, output is the input delayed by 5 pixels.
- Underflow: in STREAM, drain to empty, then hold rd_ready 3 cycles -> underflow=1 and stays 1. Refill -> underflow still 1. Flush -> underflow=0, count=0, streaming=0.
- Flush versus traffic and async reset: assert flush with wr_valid=rd_ready=1 at count=10 -> no write, no pop, next cycle count=0, state FILL. Assert rst between clock edges at count=9 -> count=0 and rd_valid=0 immediately.
